gost_io_ctrl: RTL and testbench

Byte-serial sequencer for the `gost_28147_89` cipher core. It assembles a 256-bit key and a 64-bit data block from 8-bit writes, launches the core with a one-cycle `load` pulse, and waits for `done` under a watchdog. It then streams the 64-bit result out as eight bytes with a valid/ready handshake. It sits between the top-level pin wrapper and the core, replacing the constant key/data tie-offs.

---
 rtl/gost_io_ctrl_if.sv | 23 ++
 rtl/gost_io_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_gost_io_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gost_io_ctrl_if.sv
// Byte-stream handshake bundle for gost_io_ctrl.
//   in_valid/in_sel/in_data/in_ready : byte write port (key or data select)
//   out_data/out_valid/out_ready     : result byte stream (valid/ready)
// master = upstream/downstream environment, slave = the sequencer.
interface gost_io_ctrl_if;
    logic       in_valid;
    logic       in_sel;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/gost_io_ctrl.sv
// Byte-serial sequencer for the gost_28147_89 core: assembles a 256-bit key
// and 64-bit block from byte writes, launches the core, waits for done under
// a watchdog, then streams the 64-bit result out as eight bytes.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   io (slave)    : byte write port and result byte stream
//   mode, abort   : cipher direction (sampled at launch), synchronous abort
//   busy, key_ok  : status; err_timeout (sticky), err_nokey (pulse)
//   core_*        : load/mode/key/pdata to the core, cdata/done from it
module gost_io_ctrl #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TO_W    = 10
) (
    input  logic           clk,
    input  logic           rst,
    gost_io_ctrl_if.slave  io,
    input  logic           mode,
    input  logic           abort,
    output logic           busy,
    output logic           key_ok,
    output logic           err_timeout,
    output logic           err_nokey,
    output logic           core_load,
    output logic           core_mode,
    output logic [255:0]   core_key,
    output logic [63:0]    core_pdata,
    input  logic [63:0]    core_cdata,
    input  logic           core_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [255:0]    r_key;
    logic [4:0]      r_key_cnt;
    logic            r_key_ok;
    logic [63:0]     r_pdata;
    logic [2:0]      r_dat_cnt;
    logic [63:0]     r_shift;
    logic [2:0]      r_out_cnt;
    logic [TO_W-1:0] r_wdog;
    logic            r_err_timeout;
    logic            r_err_nokey;
    logic            r_core_load;
    logic            r_core_mode;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_out_valid;

    logic            w_key_wr;
    logic            w_dat_wr;
    logic            w_launch;
    logic            w_capture;
    logic            w_timeout;
    logic            w_shift;
    logic            w_nokey;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath strobes; abort overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        w_key_wr    = 1'b0;
        w_dat_wr    = 1'b0;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_shift     = 1'b0;
        w_nokey     = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        if (!io.in_sel) begin
                            w_key_wr = 1'b1;
                        end else begin
                            w_dat_wr = 1'b1;
                            if (r_dat_cnt == 3'd7) begin
                                if (r_key_ok) begin
                                    w_launch    = 1'b1;
                                    w_state_nxt = S_LAUNCH;
                                end else begin
                                    w_nokey = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_LAUNCH: w_state_nxt = S_WAIT;
                S_WAIT: begin
                    // Watchdog at zero marks the first WAIT cycle: a done
                    // left over from an earlier block is not trusted there.
                    if ((r_wdog != '0) && core_done) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end else if (r_wdog == WDOG_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && io.out_ready) begin
                        w_shift = 1'b1;
                        if (r_out_cnt == 3'd7) w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Key assembly; byte n lands at bit 255-8n, i.e. index {~n, 3'b111}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key     <= '0;
            r_key_cnt <= '0;
            r_key_ok  <= 1'b0;
        end else if (w_key_wr) begin
            r_key[{~r_key_cnt, 3'b111} -: 8] <= io.in_data;
            r_key_cnt <= r_key_cnt + 5'd1;
            if (r_key_cnt == 5'd0)  r_key_ok <= 1'b0;
            if (r_key_cnt == 5'd31) r_key_ok <= 1'b1;
        end
    end

    // Data block assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pdata   <= '0;
            r_dat_cnt <= '0;
        end else if (abort) begin
            r_dat_cnt <= '0;
        end else if (w_dat_wr) begin
            r_pdata[{~r_dat_cnt, 3'b111} -: 8] <= io.in_data;
            r_dat_cnt <= r_dat_cnt + 3'd1;
        end
    end

    // Watchdog, error flags and launch controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
            r_err_nokey   <= 1'b0;
            r_core_mode   <= 1'b0;
        end else begin
            r_err_nokey <= w_nokey;
            if (w_launch) begin
                r_wdog        <= '0;
                r_err_timeout <= 1'b0;
                r_core_mode   <= mode;
            end else begin
                if (r_state == S_WAIT) r_wdog <= r_wdog + TO_W'(1);
                if (w_timeout)         r_err_timeout <= 1'b1;
            end
        end
    end

    // Result shift register and transfer counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_out_cnt <= '0;
        end else if (w_capture) begin
            r_shift   <= core_cdata;
            r_out_cnt <= '0;
        end else if (w_shift) begin
            r_shift   <= {r_shift[55:0], 8'h00};
            r_out_cnt <= r_out_cnt + 3'd1;
        end
    end

    // State-decoded outputs, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_core_load <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_core_load <= (w_state_nxt == S_LAUNCH);
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.out_data  = r_shift[63:56];
    assign busy         = r_busy;
    assign key_ok       = r_key_ok;
    assign err_timeout  = r_err_timeout;
    assign err_nokey    = r_err_nokey;
    assign core_load    = r_core_load;
    assign core_mode    = r_core_mode;
    assign core_key     = r_key;
    assign core_pdata   = r_pdata;

endmodule

// File: tb/tb_gost_io_ctrl.sv
// Directed bench for gost_io_ctrl. Two instances share all stimulus:
// u_dut (default TIMEOUT) for the main flows, u_dut_to (TIMEOUT=16) for the
// watchdog. Inputs change and outputs are sampled 1 ns after rising edges.
module tb_gost_io_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid, in_sel, out_ready, mode, abort, core_done;
    logic [7:0]  in_data;
    logic [63:0] core_cdata;

    gost_io_ctrl_if ifa();
    gost_io_ctrl_if ifb();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_sel    = in_sel;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_sel    = in_sel;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    logic         a_busy, a_key_ok, a_err_timeout, a_err_nokey, a_core_load, a_core_mode;
    logic [255:0] a_core_key;
    logic [63:0]  a_core_pdata;
    logic         b_busy, b_key_ok, b_err_timeout, b_err_nokey, b_core_load, b_core_mode;
    logic [255:0] b_core_key;
    logic [63:0]  b_core_pdata;

    gost_io_ctrl #(.TIMEOUT(16), .TO_W(5)) u_dut_to (
        .clk(clk), .rst(rst), .io(ifa.slave), .mode(mode), .abort(abort),
        .busy(a_busy), .key_ok(a_key_ok), .err_timeout(a_err_timeout),
        .err_nokey(a_err_nokey), .core_load(a_core_load), .core_mode(a_core_mode),
        .core_key(a_core_key), .core_pdata(a_core_pdata),
        .core_cdata(core_cdata), .core_done(core_done)
    );

    gost_io_ctrl u_dut (
        .clk(clk), .rst(rst), .io(ifb.slave), .mode(mode), .abort(abort),
        .busy(b_busy), .key_ok(b_key_ok), .err_timeout(b_err_timeout),
        .err_nokey(b_err_nokey), .core_load(b_core_load), .core_mode(b_core_mode),
        .core_key(b_core_key), .core_pdata(b_core_pdata),
        .core_cdata(core_cdata), .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of load pulses seen by the main instance
    int n_load_b = 0;
    always @(negedge clk) if (b_core_load) n_load_b++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        mode       = 1'b0;
        abort      = 1'b0;
        core_done  = 1'b0;
        core_cdata = 64'h0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr(input logic sel, input logic [7:0] b);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_key();
        for (int n = 0; n < 32; n++) wr(1'b0, 8'(n));
    endtask

    task automatic write_block(input logic [63:0] w);
        for (int n = 0; n < 8; n++) wr(1'b1, w[63-8*n -: 8]);
    endtask

    // Accept eight bytes with out_ready held high, checking order
    task automatic drain_check(input string tag, input logic [63:0] w);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check({tag, "_byte"}, 64'(ifb.out_data), 64'(w[63-8*k -: 8]));
            tick();
        end
        check({tag, "_idle"}, 64'(ifb.in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    logic [255:0] exp_key;
    logic [63:0]  w;
    int           idx;
    int           load_mark;

    initial begin
        do_reset();

        // Reset values
        check("rst_in_ready",  64'(ifb.in_ready),  64'd1);
        check("rst_busy",      64'(b_busy),        64'd0);
        check("rst_key_ok",    64'(b_key_ok),      64'd0);
        check("rst_out_valid", 64'(ifb.out_valid), 64'd0);
        check("rst_out_data",  64'(ifb.out_data),  64'd0);
        check("rst_core_load", 64'(b_core_load),   64'd0);
        check("rst_err_to",    64'(b_err_timeout), 64'd0);
        check("rst_pdata",     b_core_pdata,       64'd0);

        // Key and block round trip
        load_mark = n_load_b;
        for (int n = 0; n < 31; n++) wr(1'b0, 8'(n));
        check("rt_key_ok_31", 64'(b_key_ok), 64'd0);
        wr(1'b0, 8'h1F);
        check("rt_key_ok_32", 64'(b_key_ok), 64'd1);
        for (int n = 0; n < 32; n++) exp_key[255-8*n -: 8] = 8'(n);
        for (int i = 0; i < 4; i++)
            check("rt_core_key", b_core_key[255-64*i -: 64], exp_key[255-64*i -: 64]);
        mode = 1'b1;
        write_block(64'h0102030405060708);
        mode = 1'b0;
        check("rt_pdata",     b_core_pdata,       64'h0102030405060708);
        check("rt_core_load", 64'(b_core_load),   64'd1);
        check("rt_core_mode", 64'(b_core_mode),   64'd1);
        check("rt_in_ready",  64'(ifb.in_ready),  64'd0);
        repeat (40) tick();
        check("rt_wait_busy", 64'(b_busy),        64'd1);
        check("rt_wait_ov",   64'(ifb.out_valid), 64'd0);
        core_cdata = 64'hA1B2C3D4E5F60718;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        check("rt_out_valid", 64'(ifb.out_valid), 64'd1);
        drain_check("rt", 64'hA1B2C3D4E5F60718);
        check("rt_ov_low",    64'(ifb.out_valid), 64'd0);
        check("rt_load_cnt",  64'(n_load_b - load_mark), 64'd1);

        // Missing key
        do_reset();
        load_mark = n_load_b;
        for (int n = 0; n < 7; n++) wr(1'b1, 8'(n + 1));
        check("nk_pulse_early", 64'(b_err_nokey), 64'd0);
        wr(1'b1, 8'h08);
        check("nk_pulse",     64'(b_err_nokey),  64'd1);
        check("nk_in_ready",  64'(ifb.in_ready), 64'd1);
        check("nk_core_load", 64'(b_core_load),  64'd0);
        tick();
        check("nk_pulse_end", 64'(b_err_nokey),  64'd0);
        check("nk_load_cnt",  64'(n_load_b - load_mark), 64'd0);
        // dat_cnt restarted: a full block now launches on its 8th byte only
        write_key();
        for (int n = 0; n < 7; n++) wr(1'b1, 8'(n + 1));
        check("nk_no_early_load", 64'(b_core_load), 64'd0);
        wr(1'b1, 8'h08);
        check("nk_relaunch", 64'(b_core_load), 64'd1);

        // Stale done held across launch: ignored in first WAIT cycle
        do_reset();
        write_key();
        core_cdata = 64'h1122334455667788;
        core_done  = 1'b1;
        write_block(64'h1111111111111111);
        check("sd_launch", 64'(b_core_load), 64'd1);
        tick();
        check("sd_wait1_ov", 64'(ifb.out_valid), 64'd0);
        tick();
        check("sd_wait2_ov",   64'(ifb.out_valid), 64'd0);
        check("sd_wait2_busy", 64'(b_busy),        64'd1);
        tick();
        check("sd_capture",  64'(ifb.out_valid), 64'd1);
        check("sd_first",    64'(ifb.out_data),  64'h11);
        core_done = 1'b0;
        drain_check("sd", 64'h1122334455667788);

        // Stale done dropped in first WAIT cycle, real done at cycle 10
        core_cdata = 64'hDEADBEEF00000000;
        core_done  = 1'b1;
        write_block(64'h2222222222222222);
        tick();
        core_done = 1'b0;
        repeat (9) tick();
        check("sd10_ov_low", 64'(ifb.out_valid), 64'd0);
        core_cdata = 64'hCAFEBABE12345678;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        check("sd10_capture", 64'(ifb.out_valid), 64'd1);
        drain_check("sd10", 64'hCAFEBABE12345678);

        // Watchdog on the TIMEOUT=16 instance
        do_reset();
        write_key();
        write_block(64'h3333333333333333);
        check("wd_launch", 64'(a_core_load), 64'd1);
        tick();
        repeat (15) tick();
        check("wd_before_err",  64'(a_err_timeout), 64'd0);
        check("wd_before_busy", 64'(a_busy),        64'd1);
        tick();
        check("wd_err",      64'(a_err_timeout), 64'd1);
        check("wd_in_ready", 64'(ifa.in_ready),  64'd1);
        check("wd_busy",     64'(a_busy),        64'd0);
        check("wd_no_ov",    64'(ifa.out_valid), 64'd0);
        tick();
        check("wd_sticky",   64'(a_err_timeout), 64'd1);
        write_block(64'h4444444444444444);
        check("wd_relaunch", 64'(a_core_load),   64'd1);
        check("wd_cleared",  64'(a_err_timeout), 64'd0);

        // Output backpressure
        do_reset();
        write_key();
        write_block(64'h5555555555555555);
        repeat (5) tick();
        w = 64'h9A8B7C6D5E4F3021;
        core_cdata = w;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        out_ready  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("bp_stall_data",  64'(ifb.out_data),  64'h7C);
            check("bp_stall_valid", 64'(ifb.out_valid), 64'd1);
            tick();
        end
        idx = 2;
        for (int j = 0; j < 40 && idx < 8; j++) begin
            out_ready = ~j[0];
            check("bp_data",  64'(ifb.out_data),  64'(w[63-8*idx -: 8]));
            check("bp_valid", 64'(ifb.out_valid), 64'd1);
            tick();
            if (out_ready) idx++;
        end
        out_ready = 1'b0;
        check("bp_count",    64'(idx),           64'd8);
        check("bp_idle",     64'(ifb.in_ready),  64'd1);
        check("bp_ov_low",   64'(ifb.out_valid), 64'd0);

        // Abort during WAIT, then a fresh block
        do_reset();
        write_key();
        write_block(64'h6666666666666666);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_in_ready", 64'(ifb.in_ready),  64'd1);
        check("ab_busy",     64'(b_busy),        64'd0);
        check("ab_key_ok",   64'(b_key_ok),      64'd1);
        check("ab_ov",       64'(ifb.out_valid), 64'd0);
        write_block(64'h7777777777777777);
        check("ab_relaunch", 64'(b_core_load), 64'd1);
        repeat (3) tick();
        core_cdata = 64'h0F1E2D3C4B5A6978;
        core_done  = 1'b1;
        tick();
        core_done  = 1'b0;
        check("ab_capture",  64'(ifb.out_data), 64'h0F);

        // Reset asserted mid-DRAIN acts without a clock edge
        check("rr_pre_ov", 64'(ifb.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rr_ov",        64'(ifb.out_valid), 64'd0);
        check("rr_busy",      64'(b_busy),        64'd0);
        check("rr_key_ok",    64'(b_key_ok),      64'd0);
        check("rr_core_load", 64'(b_core_load),   64'd0);
        check("rr_in_ready",  64'(ifb.in_ready),  64'd1);
        check("rr_out_data",  64'(ifb.out_data),  64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
